// File: rtl/eater_pkg.sv
// Shared types and widths for the SAP run controller: state encoding and RAM port sizes.
package eater_pkg;

   localparam int RAM_ADDR_W = 4;
   localparam int DATA_W     = 8;

   typedef enum logic [2:0] {
      S_RESET = 3'd0,
      S_RUN   = 3'd1,
      S_HALT  = 3'd2,
      S_LOAD  = 3'd3
   } state_e;

endpackage

// File: rtl/eater_run_ctrl_if.sv
// Host loader write port plus the resulting program-RAM write strobe, one bundle.
interface eater_run_ctrl_if;

   logic                              load_valid_i;
   logic                              load_ready_o;
   logic [eater_pkg::RAM_ADDR_W-1:0]  load_addr_i;
   logic [eater_pkg::DATA_W-1:0]      load_data_i;
   logic                              load_last_i;
   logic                              ram_we_o;
   logic [eater_pkg::RAM_ADDR_W-1:0]  ram_addr_o;
   logic [eater_pkg::DATA_W-1:0]      ram_data_o;

   modport slave (
      input  load_valid_i, load_addr_i, load_data_i, load_last_i,
      output load_ready_o, ram_we_o, ram_addr_o, ram_data_o
   );

   modport master (
      output load_valid_i, load_addr_i, load_data_i, load_last_i,
      input  load_ready_o, ram_we_o, ram_addr_o, ram_data_o
   );

endinterface

// File: rtl/eater_debounce.sv
// 2-flop synchronizer followed by a stability filter; a new level is accepted after
// DEBOUNCE_CYCLES consecutive differing samples, and rise_o pulses one cycle on 0->1.
module eater_debounce #(
   parameter int DEBOUNCE_CYCLES = 65536
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic din_i,
   output logic level_o,
   output logic rise_o
);

   localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          level_q, level_d;
   logic          rise_q, rise_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d = din_i;
      sync2_d = sync1_q;
      level_d = level_q;
      rise_d  = 1'b0;
      cnt_d   = '0;
      // Any sample matching the current level restarts the stability count.
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;

endmodule

// File: rtl/eater_run_ctrl.sv
// CPU sequencer: owns CPU reset/clock-enable (free-run, single-step, halt) and freezes the CPU
// while the host loads program RAM; host writes strobe RAM one cycle after each handshake.
module eater_run_ctrl
   import eater_pkg::*;
#(
   parameter int RESET_CYCLES    = 4,
   parameter int RUN_PERIOD      = 1000000,
   parameter int DEBOUNCE_CYCLES = 65536
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              run_mode_i,
   input  logic              step_btn_i,
   input  logic              halt_i,
   eater_run_ctrl_if.slave   ld,
   output logic              cpu_reset_o,
   output logic              cpu_clk_en_o,
   output logic [2:0]        state_o
);

   localparam int                RST_W    = $clog2(RESET_CYCLES + 1);
   localparam int                PER_W    = $clog2(RUN_PERIOD);
   localparam logic [RST_W-1:0]  RST_LAST = RST_W'(RESET_CYCLES - 1);
   localparam logic [PER_W-1:0]  PER_LAST = PER_W'(RUN_PERIOD - 1);

   logic mode_lvl, mode_rise;
   logic btn_lvl, step_ev;
   logic unused_dbg;

   eater_debounce #(.DEBOUNCE_CYCLES(2)) u_mode_sync (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .din_i   (run_mode_i),
      .level_o (mode_lvl),
      .rise_o  (mode_rise)
   );

   eater_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .din_i   (step_btn_i),
      .level_o (btn_lvl),
      .rise_o  (step_ev)
   );

   assign unused_dbg = ^{mode_rise, btn_lvl};

   state_e                  state_q, state_d;
   logic [RST_W-1:0]        rst_cnt_q, rst_cnt_d;
   logic [PER_W-1:0]        per_cnt_q, per_cnt_d;
   logic                    mode_prev_q, mode_prev_d;
   logic                    cpu_reset_q, cpu_reset_d;
   logic                    load_ready_q, load_ready_d;
   logic                    ram_we_q, ram_we_d;
   logic [RAM_ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]       ram_data_q, ram_data_d;

   logic mode_chg;
   logic pulse;
   logic hs;

   // A mode flip restarts the period and swallows a coincident step event.
   assign mode_chg = (mode_lvl != mode_prev_q);
   assign hs       = ld.load_valid_i & load_ready_q;

   always_comb begin
      pulse = 1'b0;
      if (state_q == S_RUN && !mode_chg) begin
         pulse = mode_lvl ? (per_cnt_q == PER_LAST) : step_ev;
      end
   end

   always_comb begin
      state_d     = state_q;
      rst_cnt_d   = '0;
      per_cnt_d   = '0;
      mode_prev_d = mode_lvl;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_data_d  = ram_data_q;
      case (state_q)
         S_RESET: begin
            if (rst_cnt_q == RST_LAST) begin
               state_d = ld.load_valid_i ? S_LOAD : S_RUN;
            end else begin
               rst_cnt_d = rst_cnt_q + 1'b1;
            end
         end
         S_RUN: begin
            if (ld.load_valid_i) begin
               state_d = S_LOAD;
            end else if (pulse && halt_i) begin
               state_d = S_HALT;
            end else if (mode_lvl && !mode_chg) begin
               per_cnt_d = (per_cnt_q == PER_LAST) ? '0 : per_cnt_q + 1'b1;
            end
         end
         S_HALT: begin
            if (ld.load_valid_i) begin
               state_d = S_LOAD;
            end else if (step_ev) begin
               state_d = S_RESET;
            end
         end
         S_LOAD: begin
            if (hs) begin
               ram_we_d   = 1'b1;
               ram_addr_d = ld.load_addr_i;
               ram_data_d = ld.load_data_i;
               if (ld.load_last_i) begin
                  state_d = S_RESET;
               end
            end
         end
         default: state_d = S_RESET;
      endcase
      cpu_reset_d  = (state_d == S_RESET);
      load_ready_d = (state_d == S_LOAD);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= S_RESET;
         rst_cnt_q    <= '0;
         per_cnt_q    <= '0;
         mode_prev_q  <= 1'b0;
         cpu_reset_q  <= 1'b1;
         load_ready_q <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         rst_cnt_q    <= rst_cnt_d;
         per_cnt_q    <= per_cnt_d;
         mode_prev_q  <= mode_prev_d;
         cpu_reset_q  <= cpu_reset_d;
         load_ready_q <= load_ready_d;
         ram_we_q     <= ram_we_d;
         ram_addr_q   <= ram_addr_d;
         ram_data_q   <= ram_data_d;
      end
   end

   assign cpu_reset_o     = cpu_reset_q;
   assign cpu_clk_en_o    = pulse & ~halt_i;
   assign state_o         = state_q;
   assign ld.load_ready_o = load_ready_q;
   assign ld.ram_we_o     = ram_we_q;
   assign ld.ram_addr_o   = ram_addr_q;
   assign ld.ram_data_o   = ram_data_q;

endmodule
